// File: rtl/copia_memoria_dados_if.sv
// Data-memory bus driven by the transfer engine: address, write data, strobes and read data.
interface copia_memoria_dados_if #(
  parameter int LARGURA_END  = 8,
  parameter int LARGURA_DADO = 8
);
  logic [LARGURA_END-1:0]  endereco;
  logic [LARGURA_DADO-1:0] dadoEscrito;
  logic                    escMem;
  logic                    lerMem;
  logic [LARGURA_DADO-1:0] dadoLido;

  modport master (output endereco, output dadoEscrito, output escMem, output lerMem,
                  input dadoLido);
  modport slave  (input endereco, input dadoEscrito, input escMem, input lerMem,
                  output dadoLido);
endinterface

// File: rtl/copia_memoria_dados.sv
// Memory-to-memory copy/fill engine on the 8-bit data-memory port.
// Optional running XOR of written bytes on port soma when SOMA_VERIFICACAO_EN is defined.
module copia_memoria_dados #(
  parameter int LARGURA_END  = 8,
  parameter int LARGURA_DADO = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    inicio,
  input  logic                    modo,
  input  logic [LARGURA_END-1:0]  origem,
  input  logic [LARGURA_END-1:0]  destino,
  input  logic [LARGURA_END:0]    tamanho,
  input  logic [LARGURA_DADO-1:0] valor_preenche,
  input  logic                    aborta,
  copia_memoria_dados_if.master   mem,
  output logic                    ocupado,
  output logic                    concluido,
`ifdef SOMA_VERIFICACAO_EN
  output logic [LARGURA_DADO-1:0] soma,
`endif
  output logic [LARGURA_END:0]    restante
);

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] LEITURA = 2'd1;
  localparam logic [1:0] ESCRITA = 2'd2;
  localparam logic [1:0] FIM     = 2'd3;

  localparam logic [LARGURA_END:0]   CNT_MAX = {1'b1, {LARGURA_END{1'b0}}};
  localparam logic [LARGURA_END:0]   CNT_UM  = {{LARGURA_END{1'b0}}, 1'b1};
  localparam logic [LARGURA_END-1:0] END_UM  = {{(LARGURA_END-1){1'b0}}, 1'b1};

  logic [1:0]              estado_q, estado_d;
  logic                    modo_q, modo_d;
  logic [LARGURA_DADO-1:0] valor_q, valor_d;
  logic [LARGURA_END-1:0]  src_q, src_d;
  logic [LARGURA_END-1:0]  dst_q, dst_d;
  logic [LARGURA_END:0]    restante_q, restante_d;
  logic [LARGURA_END-1:0]  endereco_q, endereco_d;
  logic [LARGURA_DADO-1:0] dado_q, dado_d;
  logic                    esc_q, esc_d;
  logic                    ler_q, ler_d;
  logic                    ocupado_q, ocupado_d;
  logic                    concluido_q, concluido_d;
  logic [LARGURA_END:0]    contagem;
`ifdef SOMA_VERIFICACAO_EN
  logic [LARGURA_DADO-1:0] soma_q, soma_d;
`endif

  always_comb begin
    contagem = (tamanho > CNT_MAX) ? CNT_MAX : tamanho;
  end

  // Output registers are loaded with the values of the state being entered,
  // so every bus signal is a clean flop output during its cycle.
  always_comb begin
    estado_d    = estado_q;
    modo_d      = modo_q;
    valor_d     = valor_q;
    src_d       = src_q;
    dst_d       = dst_q;
    restante_d  = restante_q;
    endereco_d  = endereco_q;
    dado_d      = dado_q;
    esc_d       = 1'b0;
    ler_d       = 1'b0;
    ocupado_d   = ocupado_q;
    concluido_d = 1'b0;
`ifdef SOMA_VERIFICACAO_EN
    soma_d      = soma_q;
`endif
    case (estado_q)
      OCIOSO: begin
        if (inicio) begin
          modo_d     = modo;
          valor_d    = valor_preenche;
          src_d      = origem;
          dst_d      = destino;
          restante_d = contagem;
          ocupado_d  = 1'b1;
`ifdef SOMA_VERIFICACAO_EN
          soma_d     = '0;
`endif
          if (contagem == '0) begin
            estado_d    = FIM;
            concluido_d = 1'b1;
          end else if (modo) begin
            estado_d   = ESCRITA;
            endereco_d = destino;
            dado_d     = valor_preenche;
            esc_d      = 1'b1;
          end else begin
            estado_d   = LEITURA;
            endereco_d = origem;
            ler_d      = 1'b1;
          end
        end
      end
      LEITURA: begin
        if (aborta) begin
          estado_d    = FIM;
          concluido_d = 1'b1;
        end else begin
          estado_d   = ESCRITA;
          endereco_d = dst_q;
          dado_d     = mem.dadoLido;
          esc_d      = 1'b1;
        end
      end
      ESCRITA: begin
        // The write in flight always commits, even when aborting.
        restante_d = restante_q - CNT_UM;
        src_d      = src_q + END_UM;
        dst_d      = dst_q + END_UM;
`ifdef SOMA_VERIFICACAO_EN
        soma_d     = soma_q ^ dado_q;
`endif
        if (aborta || restante_q == CNT_UM) begin
          estado_d    = FIM;
          concluido_d = 1'b1;
        end else if (modo_q) begin
          endereco_d = dst_q + END_UM;
          dado_d     = valor_q;
          esc_d      = 1'b1;
        end else begin
          estado_d   = LEITURA;
          endereco_d = src_q + END_UM;
          ler_d      = 1'b1;
        end
      end
      FIM: begin
        estado_d  = OCIOSO;
        ocupado_d = 1'b0;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q    <= OCIOSO;
      modo_q      <= 1'b0;
      valor_q     <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      restante_q  <= '0;
      endereco_q  <= '0;
      dado_q      <= '0;
      esc_q       <= 1'b0;
      ler_q       <= 1'b0;
      ocupado_q   <= 1'b0;
      concluido_q <= 1'b0;
`ifdef SOMA_VERIFICACAO_EN
      soma_q      <= '0;
`endif
    end else begin
      estado_q    <= estado_d;
      modo_q      <= modo_d;
      valor_q     <= valor_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      restante_q  <= restante_d;
      endereco_q  <= endereco_d;
      dado_q      <= dado_d;
      esc_q       <= esc_d;
      ler_q       <= ler_d;
      ocupado_q   <= ocupado_d;
      concluido_q <= concluido_d;
`ifdef SOMA_VERIFICACAO_EN
      soma_q      <= soma_d;
`endif
    end
  end

  assign mem.endereco    = endereco_q;
  assign mem.dadoEscrito = dado_q;
  assign mem.escMem      = esc_q;
  assign mem.lerMem      = ler_q;
  assign ocupado         = ocupado_q;
  assign concluido       = concluido_q;
  assign restante        = restante_q;
`ifdef SOMA_VERIFICACAO_EN
  assign soma            = soma_q;
`endif

endmodule

// File: tb/tb_copia_memoria_dados.sv
// Directed bench: a per-cycle expected timeline built from the transfer rules, plus a memory image model.
module tb_copia_memoria_dados;

  logic       clock, reset_n, inicio, modo, aborta;
  logic [7:0] origem, destino, valor_preenche;
  logic [8:0] tamanho, restante;
  logic       ocupado, concluido;
`ifdef SOMA_VERIFICACAO_EN
  logic [7:0] soma;
`endif

  logic       pre_we;
  logic [7:0] pre_addr, pre_data, rd_q;
  logic [7:0] mem [256];
  logic [7:0] mem_model [256];

  typedef struct {
    bit         le, esc, conc, ocup, abort_in, inicio_in;
    logic [7:0] ender, dado, soma;
    logic [8:0] rest;
  } exp_t;
  exp_t q [$];

  int n_vec, n_err, esc_seen, ler_seen, conc_seen;

  copia_memoria_dados_if #(.LARGURA_END(8), .LARGURA_DADO(8)) bus ();

  copia_memoria_dados #(.LARGURA_END(8), .LARGURA_DADO(8)) dut (
    .clock(clock), .reset_n(reset_n), .inicio(inicio), .modo(modo),
    .origem(origem), .destino(destino), .tamanho(tamanho),
    .valor_preenche(valor_preenche), .aborta(aborta), .mem(bus),
    .ocupado(ocupado), .concluido(concluido),
`ifdef SOMA_VERIFICACAO_EN
    .soma(soma),
`endif
    .restante(restante)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory environment: commit on rising edge, read on falling edge.
  always @(posedge clock) begin
    if (bus.escMem) mem[bus.endereco] <= bus.dadoEscrito;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end
  always @(negedge clock) begin
    if (bus.lerMem) rd_q <= mem[bus.endereco];
  end
  assign bus.dadoLido = rd_q;

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nome, act, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    @(negedge clock);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clock);
    #1 pre_we = 1'b0;
    mem_model[a] = d;
  endtask

  task automatic mem_cmp(input string tag);
    int bad, first;
    bad = 0; first = -1;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== mem_model[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s.mem: %0d bytes differ, first at 0x%0h got 0x%0h expected 0x%0h",
               tag, bad, first, mem[first], mem_model[first]);
    end
  endtask

  function automatic exp_t rec(bit le, bit esc, bit conc, bit ocup, logic [7:0] a,
                               logic [7:0] d, logic [8:0] r, logic [7:0] ck);
    exp_t e;
    e.le = le; e.esc = esc; e.conc = conc; e.ocup = ocup;
    e.ender = a; e.dado = d; e.rest = r; e.soma = ck;
    e.abort_in = 1'b0; e.inicio_in = 1'b0;
    return e;
  endfunction

  // Expected cycle-by-cycle behaviour after acceptance, and the resulting memory image.
  task automatic build(input bit md, input logic [7:0] org, input logic [7:0] dst,
                       input logic [8:0] tam, input logic [7:0] val,
                       input int abort_w, input int poke_at);
    int n;
    logic [7:0] s, d, b, ck;
    logic [8:0] rem;
    exp_t e;
    n = (tam > 9'd256) ? 256 : int'(tam);
    s = org; d = dst; ck = 8'h00; rem = 9'(n);
    q.delete();
    for (int i = 0; i < n; i++) begin
      if (!md) begin
        q.push_back(rec(1, 0, 0, 1, s, 8'h00, rem, ck));
        b = mem_model[s];
      end else begin
        b = val;
      end
      e = rec(0, 1, 0, 1, d, b, rem, ck);
      e.abort_in = (i + 1 == abort_w);
      q.push_back(e);
      mem_model[d] = b;
      ck  = ck ^ b;
      rem = rem - 9'd1;
      s   = s + 8'd1;
      d   = d + 8'd1;
      if (i + 1 == abort_w) break;
    end
    q.push_back(rec(0, 0, 1, 1, 8'h00, 8'h00, rem, ck));
    for (int i = 0; i < 3; i++) q.push_back(rec(0, 0, 0, 0, 8'h00, 8'h00, rem, ck));
    if (poke_at >= 0) q[poke_at].inicio_in = 1'b1;
  endtask

  task automatic start(input bit md, input logic [7:0] org, input logic [7:0] dst,
                       input logic [8:0] tam, input logic [7:0] val, input bit ab);
    @(negedge clock);
    modo = md; origem = org; destino = dst; tamanho = tam; valor_preenche = val;
    inicio = 1'b1; aborta = ab;
    @(posedge clock);
    #1 inicio = 1'b0; aborta = 1'b0;
  endtask

  // Walks the expected timeline one cycle per record; the queue is finite, so this always ends.
  task automatic run(input string tag);
    exp_t e;
    esc_seen = 0; ler_seen = 0; conc_seen = 0;
    while (q.size() > 0) begin
      @(negedge clock);
      e = q.pop_front();
      if (bus.escMem) esc_seen++;
      if (bus.lerMem) ler_seen++;
      if (concluido) conc_seen++;
      chk({tag, ".lerMem"}, 32'(bus.lerMem), 32'(e.le));
      chk({tag, ".escMem"}, 32'(bus.escMem), 32'(e.esc));
      chk({tag, ".concluido"}, 32'(concluido), 32'(e.conc));
      chk({tag, ".ocupado"}, 32'(ocupado), 32'(e.ocup));
      chk({tag, ".restante"}, 32'(restante), 32'(e.rest));
      if (e.le || e.esc) chk({tag, ".endereco"}, 32'(bus.endereco), 32'(e.ender));
      if (e.esc) chk({tag, ".dadoEscrito"}, 32'(bus.dadoEscrito), 32'(e.dado));
`ifdef SOMA_VERIFICACAO_EN
      chk({tag, ".soma"}, 32'(soma), 32'(e.soma));
`endif
      aborta = e.abort_in;
      inicio = e.inicio_in;
      if (e.inicio_in) begin
        modo = 1'b1; destino = 8'h00; tamanho = 9'd3; valor_preenche = 8'hEE;
      end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    inicio = 0; modo = 0; aborta = 0; origem = 0; destino = 0; tamanho = 0;
    valor_preenche = 0; pre_we = 0; pre_addr = 0; pre_data = 0;
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst.endereco", 32'(bus.endereco), 0);
    chk("rst.dadoEscrito", 32'(bus.dadoEscrito), 0);
    chk("rst.escMem", 32'(bus.escMem), 0);
    chk("rst.lerMem", 32'(bus.lerMem), 0);
    chk("rst.ocupado", 32'(ocupado), 0);
    chk("rst.concluido", 32'(concluido), 0);
    chk("rst.restante", 32'(restante), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 256; i++) load(8'(i), 8'(i * 7 + 3));
    load(8'h10, 8'hA1); load(8'h11, 8'hB2); load(8'h12, 8'hC3); load(8'h13, 8'hD4);

    // Copy 4 bytes: 8 transfer cycles + FIM.
    start(0, 8'h10, 8'h40, 9'd4, 8'h00, 0);
    build(0, 8'h10, 8'h40, 9'd4, 8'h00, 0, -1);
    chk("copy.timeline_len", 32'(q.size()), 12);
    run("copy");
    mem_cmp("copy");
    chk("copy.m40", 32'(mem[8'h40]), 32'h A1);
    chk("copy.m43", 32'(mem[8'h43]), 32'h D4);
    chk("copy.conc_pulses", 32'(conc_seen), 1);
    chk("copy.restante_end", 32'(restante), 0);

    // Fill wrapping past 0xFF.
    start(1, 8'h00, 8'hFE, 9'd4, 8'h5A, 0);
    build(1, 8'h00, 8'hFE, 9'd4, 8'h5A, 0, -1);
    run("fill");
    mem_cmp("fill");
    chk("fill.mFF", 32'(mem[8'hFF]), 32'h5A);
    chk("fill.m01", 32'(mem[8'h01]), 32'h5A);
    chk("fill.esc_cycles", 32'(esc_seen), 4);

    // Zero length: straight to FIM.
    start(0, 8'h10, 8'h50, 9'd0, 8'h00, 0);
    build(0, 8'h10, 8'h50, 9'd0, 8'h00, 0, -1);
    chk("zero.timeline_len", 32'(q.size()), 4);
    run("zero");
    chk("zero.strobes", 32'(esc_seen + ler_seen), 0);
    mem_cmp("zero");

    // Abort in the 3rd write, with a stray inicio during the transfer.
    start(0, 8'h10, 8'h60, 9'd10, 8'h00, 0);
    build(0, 8'h10, 8'h60, 9'd10, 8'h00, 3, 1);
    run("abort");
    mem_cmp("abort");
    chk("abort.bytes", 32'(esc_seen), 3);
    chk("abort.restante", 32'(restante), 7);
    chk("abort.conc_pulses", 32'(conc_seen), 1);

    // inicio and aborta together in OCIOSO: inicio wins.
    start(1, 8'h00, 8'h90, 9'd2, 8'h3C, 1);
    build(1, 8'h00, 8'h90, 9'd2, 8'h3C, 0, -1);
    run("inicio_aborta");
    mem_cmp("inicio_aborta");

    // Reset dropped during the 3rd fill write.
    start(1, 8'h00, 8'h20, 9'd8, 8'hE7, 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("rstmid.pre_esc", 32'(bus.escMem), 1);
    chk("rstmid.pre_end", 32'(bus.endereco), 32'h22);
    #1 reset_n = 1'b0;
    #1;
    chk("rstmid.escMem", 32'(bus.escMem), 0);
    chk("rstmid.ocupado", 32'(ocupado), 0);
    chk("rstmid.restante", 32'(restante), 0);
    @(negedge clock);
    reset_n = 1'b1;
    mem_model[8'h20] = 8'hE7;
    mem_model[8'h21] = 8'hE7;
    mem_cmp("rstmid");
    chk("rstmid.m21", 32'(mem[8'h21]), 32'hE7);

    // Oversized count saturates to 256 writes.
    start(1, 8'h00, 8'h80, 9'h1FF, 8'h77, 0);
    build(1, 8'h00, 8'h80, 9'h1FF, 8'h77, 0, -1);
    run("sat");
    mem_cmp("sat");
    chk("sat.esc_cycles", 32'(esc_seen), 256);

    // Forward copy over an overlapping region replicates the first byte.
    load(8'h00, 8'h01); load(8'h01, 8'h02); load(8'h02, 8'h03);
    start(0, 8'h00, 8'h01, 9'd3, 8'h00, 0);
    build(0, 8'h00, 8'h01, 9'd3, 8'h00, 0, -1);
    run("overlap");
    mem_cmp("overlap");
    chk("overlap.m02", 32'(mem[8'h02]), 32'h01);
    chk("overlap.m03", 32'(mem[8'h03]), 32'h01);
`ifdef SOMA_VERIFICACAO_EN
    chk("overlap.soma", 32'(soma), 32'h01);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
